// File: rtl/basic_circuit.sv
// ---------------------------------------------------------------------------
// basic_circuit
//   Nine-input, single-output two-level gate network used as the reference
//   combinational block of the logic-gate suite, plus synchronous observation
//   points for clocked benches.
//
//   Optional feature macro: BASIC_CIRCUIT_CNT_EN
//     defined   -> ones_cnt counts clk edges that sample t==1, saturating at
//                  2**CNT_W-1.
//     undefined -> no counter flops; ones_cnt is tied to 0. The port list is
//                  the same in both builds.
//
// Parameters
//   CNT_W     width of ones_cnt
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous, active-low reset
//   a..i      in   1 ea   independent data inputs (vector n = {i,h,...,a})
//   t         out  1      combinational function output (no clk/rst_n path)
//   t_q       out  1      t registered on clk
//   ones_cnt  out  CNT_W  saturating count of edges sampling t==1
// ---------------------------------------------------------------------------
module basic_circuit #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    input  logic             h,
    input  logic             i,
    output logic             t,
    output logic             t_q,
    output logic [CNT_W-1:0] ones_cnt
);

    // First level of the gate network.
    logic x1;
    logic x2;
    logic x3;
    logic x4;

    assign x1 = a & b;
    assign x2 = c | d;
    assign x3 = ~(e ^ f);
    assign x4 = g & ~h;

    // Second level; purely combinational, X inputs are allowed to give X.
    assign t = ((x1 | x2) & x3) ^ (x4 | i);

    // Registered copy of t: lags the combinational output by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= 1'b0;
        end else begin
            t_q <= t;
        end
    end

`ifdef BASIC_CIRCUIT_CNT_EN
    // Saturating ones counter. The all-ones test stops the increment so the
    // count never wraps back to zero on long runs of t==1.
    logic cnt_full;

    assign cnt_full = &ones_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (t && !cnt_full) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end
`else
    // Counter compiled out: output held at zero, no state.
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_basic_circuit.sv
// ---------------------------------------------------------------------------
// tb_basic_circuit
//   Self-checking bench for basic_circuit. Two instances share all inputs:
//   dut (CNT_W=10) and dut_s (CNT_W=3, for counter saturation). Expected
//   values come from a behavioural model of the boolean function and of the
//   registered/counter observation points.
// ---------------------------------------------------------------------------
module tb_basic_circuit;

    logic       clk;
    logic       rst_n;
    logic [8:0] n;
    logic       t;
    logic       t_q;
    logic [9:0] ones_cnt;
    logic       t_s;
    logic       t_q_s;
    logic [2:0] ones_cnt_s;

    int tests;
    int fails;

    // Model state
    logic exp_tq;
    int   m_cnt10;
    int   m_cnt3;

    basic_circuit #(.CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(n[0]), .b(n[1]), .c(n[2]), .d(n[3]), .e(n[4]),
        .f(n[5]), .g(n[6]), .h(n[7]), .i(n[8]),
        .t(t), .t_q(t_q), .ones_cnt(ones_cnt)
    );

    basic_circuit #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .a(n[0]), .b(n[1]), .c(n[2]), .d(n[3]), .e(n[4]),
        .f(n[5]), .g(n[6]), .h(n[7]), .i(n[8]),
        .t(t_s), .t_q(t_q_s), .ones_cnt(ones_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference function written from the boolean rules on the vector index.
    function automatic logic model_t(input logic [8:0] v);
        logic left;
        logic right;
        left  = ((v[0] && v[1]) || v[2] || v[3]) && (v[4] == v[5]);
        right = (v[6] && !v[7]) || v[8];
        return left != right;
    endfunction

    // Counter expectations: zero when the counter is compiled out.
    function automatic int exp_cnt10();
`ifdef BASIC_CIRCUIT_CNT_EN
        return m_cnt10;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_cnt3();
`ifdef BASIC_CIRCUIT_CNT_EN
        return m_cnt3;
`else
        return 0;
`endif
    endfunction

    // One rising edge with the model advanced for the vector currently held.
    // Returns 1 ns after the edge, well away from the next one.
    task automatic tick();
        logic tv;
        tv = model_t(n);
        @(posedge clk);
        if (rst_n) begin
            exp_tq = tv;
            if (tv) begin
                m_cnt10 = (m_cnt10 < 1023) ? m_cnt10 + 1 : 1023;
                m_cnt3  = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        exp_tq  = 1'b0;
        m_cnt10 = 0;
        m_cnt3  = 0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_regs(input string name);
        tests++;
        if (t_q !== exp_tq || t_q_s !== exp_tq) begin
            fails++;
            $display("FAIL %s t_q: got %b/%b want %b", name, t_q, t_q_s, exp_tq);
        end
        tests++;
        if (int'(ones_cnt) !== exp_cnt10() || int'(ones_cnt_s) !== exp_cnt3()) begin
            fails++;
            $display("FAIL %s ones_cnt: got %0d/%0d want %0d/%0d", name,
                     ones_cnt, ones_cnt_s, exp_cnt10(), exp_cnt3());
        end
    endtask

    task automatic test_reset();
        n     = 9'h000;
        rst_n = 1'b0;
        #3;
        exp_tq = 1'b0; m_cnt10 = 0; m_cnt3 = 0;
        tests++;
        if (t !== 1'b0 || t_q !== 1'b0 || ones_cnt !== 10'd0 || ones_cnt_s !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: t=%b t_q=%b cnt=%0d cnt_s=%0d want 0", t, t_q, ones_cnt, ones_cnt_s);
        end
        // t keeps tracking inputs while in reset; registered outputs stay 0.
        n = 9'h003;
        tick();
        tests++;
        if (t !== 1'b1 || t_q !== 1'b0 || ones_cnt !== 10'd0) begin
            fails++;
            $display("FAIL reset_track: t=%b t_q=%b cnt=%0d want t=1 t_q=0 cnt=0", t, t_q, ones_cnt);
        end
        rst_n = 1'b1;
        n = 9'h000;
        #1;
    endtask

    task automatic test_points();
        logic [8:0] vecs [8];
        logic       outs [8];
        vecs = '{9'h000, 9'h003, 9'h040, 9'h0C0, 9'h014, 9'h034, 9'h100, 9'h1FF};
        outs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            n = vecs[k];
            #1;
            tests++;
            if (t !== outs[k]) begin
                fails++;
                $display("FAIL point_%03h: t=%b want %b", vecs[k], t, outs[k]);
            end
        end
    endtask

    task automatic test_registered();
        do_reset();
        n = 9'h003;
        tick();
        check_regs("reg_after_003");
        n = 9'h000;
        #1;
        tests++;
        if (t !== 1'b0 || t_q !== 1'b1) begin
            fails++;
            $display("FAIL reg_lag: t=%b t_q=%b want t=0 t_q=1", t, t_q);
        end
        tick();
        check_regs("reg_after_000");
    endtask

    task automatic test_sweep();
        int mismatches;
        mismatches = 0;
        do_reset();
        for (int k = 0; k < 512; k++) begin
            n = 9'(k);
            #1;
            if (t !== model_t(n)) mismatches++;
            tick();
        end
        tests++;
        if (mismatches != 0) begin
            fails++;
            $display("FAIL sweep_t: %0d vectors differ from model, want 0", mismatches);
        end
        check_regs("sweep_end");
`ifdef BASIC_CIRCUIT_CNT_EN
        tests++;
        if (ones_cnt !== 10'd268) begin
            fails++;
            $display("FAIL sweep_count: got %0d want 268", ones_cnt);
        end
`else
        tests++;
        if (ones_cnt !== 10'd0) begin
            fails++;
            $display("FAIL sweep_count_off: got %0d want 0", ones_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            n = 9'(k + 1);
            tick();
        end
        // Between edges: reset must clear immediately.
        #2;
        rst_n = 1'b0;
        #1;
        exp_tq = 1'b0; m_cnt10 = 0; m_cnt3 = 0;
        check_regs("mid_reset_async");
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n = 9'h100;   // t==1: counts from zero
            tick();
        end
        check_regs("mid_reset_resume");
    endtask

    task automatic test_saturate();
        do_reset();
        n = 9'h003;
        for (int k = 0; k < 10; k++) tick();
        check_regs("saturate");
`ifdef BASIC_CIRCUIT_CNT_EN
        tests++;
        if (ones_cnt_s !== 3'd7 || ones_cnt !== 10'd10) begin
            fails++;
            $display("FAIL saturate_abs: got %0d/%0d want 7/10", ones_cnt_s, ones_cnt);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            n = 9'($urandom_range(0, 511));
            #1;
            tests++;
            if (t !== model_t(n)) begin
                fails++;
                $display("FAIL rand_t n=%03h: t=%b want %b", n, t, model_t(n));
            end
            tick();
            if (k % 50 == 49) check_regs("rand_regs");
        end
        check_regs("rand_end");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        n = '0;
        exp_tq = 1'b0;
        m_cnt10 = 0;
        m_cnt3 = 0;
        test_reset();
        test_points();
        test_registered();
        test_sweep();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
